// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU/DMA) arbiter in front of a single-port MEMORY block.
// Round-robin on ties, FRAM wait-state insertion, registered read data and one-cycle acks.
module mem_bus_arbiter #(
    parameter logic [15:0] FRAM_START = 16'h4400,
    parameter int          FRAM_WAIT  = 1,
    parameter int          CNT_W      = 3
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        CPU_req,
    input  logic [15:0] CPU_MAB,
    input  logic [15:0] CPU_MDBwrite,
    input  logic        CPU_MW,
    input  logic        CPU_BW,
    output logic        CPU_ack,
    input  logic        DMA_req,
    input  logic [15:0] DMA_MAB,
    input  logic [15:0] DMA_MDBwrite,
    input  logic        DMA_MW,
    input  logic        DMA_BW,
    output logic        DMA_ack,
    output logic [15:0] MAB,
    output logic [15:0] MDBwrite,
    output logic        MW,
    output logic        BW,
    input  logic [15:0] MDBread,
    output logic [15:0] RDATA,
    output logic [1:0]  GNT
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(FRAM_WAIT);
    localparam logic [1:0]       GNT_NONE  = 2'b00;
    localparam logic [1:0]       GNT_CPU   = 2'b01;
    localparam logic [1:0]       GNT_DMA   = 2'b10;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       mab_q, mab_d;
    logic [15:0]       mdbw_q, mdbw_d;
    logic              mw_q, mw_d;
    logic              bw_q, bw_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       rdata_q, rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              prefer_dma_q, prefer_dma_d;

    logic              cpu_eff;
    logic              dma_eff;
    logic              pick_dma;
    logic [15:0]       win_mab;
    logic [15:0]       win_mdbw;
    logic              win_mw;
    logic              win_bw;

    // A master is not eligible in the cycle its own ack is showing.
    assign cpu_eff = CPU_req && !cpu_ack_q;
    assign dma_eff = DMA_req && !dma_ack_q;

    always_comb begin
        pick_dma = dma_eff && (!cpu_eff || prefer_dma_q);
        win_mab  = pick_dma ? DMA_MAB      : CPU_MAB;
        win_mdbw = pick_dma ? DMA_MDBwrite : CPU_MDBwrite;
        win_mw   = pick_dma ? DMA_MW       : CPU_MW;
        win_bw   = pick_dma ? DMA_BW       : CPU_BW;
    end

    always_comb begin
        state_d      = state_q;
        mab_d        = mab_q;
        mdbw_d       = mdbw_q;
        mw_d         = mw_q;
        bw_d         = bw_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        cpu_ack_d    = 1'b0;
        dma_ack_d    = 1'b0;
        gnt_d        = gnt_q;
        prefer_dma_d = prefer_dma_q;

        case (state_q)
            S_IDLE: begin
                gnt_d = GNT_NONE;
                if (cpu_eff || dma_eff) begin
                    mab_d        = win_mab;
                    mdbw_d       = win_mdbw;
                    mw_d         = win_mw;
                    bw_d         = win_bw;
                    gnt_d        = pick_dma ? GNT_DMA : GNT_CPU;
                    prefer_dma_d = !pick_dma;
                    cnt_d        = (win_mab >= FRAM_START) ? WAIT_LOAD : '0;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!mw_q) begin
                        rdata_d = MDBread;
                    end
                    cpu_ack_d = (gnt_q == GNT_CPU);
                    dma_ack_d = (gnt_q == GNT_DMA);
                    gnt_d     = GNT_NONE;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mab_q        <= '0;
            mdbw_q       <= '0;
            mw_q         <= 1'b0;
            bw_q         <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            cpu_ack_q    <= 1'b0;
            dma_ack_q    <= 1'b0;
            gnt_q        <= GNT_NONE;
            prefer_dma_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mab_q        <= mab_d;
            mdbw_q       <= mdbw_d;
            mw_q         <= mw_d;
            bw_q         <= bw_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            dma_ack_q    <= dma_ack_d;
            gnt_q        <= gnt_d;
            prefer_dma_q <= prefer_dma_d;
        end
    end

    // The write strobe is confined to the last access cycle so each write hits MEMORY once.
    assign MW       = (state_q == S_ACCESS) && mw_q && (cnt_q == '0);
    assign MAB      = mab_q;
    assign MDBwrite = mdbw_q;
    assign BW       = bw_q;
    assign RDATA    = rdata_q;
    assign CPU_ack  = cpu_ack_q;
    assign DMA_ack  = dma_ack_q;
    assign GNT      = gnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: two instances (FRAM_WAIT=1 and FRAM_WAIT=3),
// each in front of a behavioural little-endian word memory with combinational read.
module tb_mem_bus_arbiter;

    logic MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    logic mem_clr;
    int   checks = 0;
    int   errors = 0;

    // Instance 0 (FRAM_WAIT=1)
    logic        rst0;
    logic        CPU_req0, CPU_MW0, CPU_BW0, DMA_req0, DMA_MW0, DMA_BW0;
    logic [15:0] CPU_MAB0, CPU_MDBwrite0, DMA_MAB0, DMA_MDBwrite0;
    logic        CPU_ack0, DMA_ack0, MW0, BW0;
    logic [15:0] MAB0, MDBwrite0, MDBread0, RDATA0;
    logic [1:0]  GNT0;

    // Instance 1 (FRAM_WAIT=3)
    logic        rst1;
    logic        CPU_req1, CPU_MW1, CPU_BW1, DMA_req1, DMA_MW1, DMA_BW1;
    logic [15:0] CPU_MAB1, CPU_MDBwrite1, DMA_MAB1, DMA_MDBwrite1;
    logic        CPU_ack1, DMA_ack1, MW1, BW1;
    logic [15:0] MAB1, MDBwrite1, MDBread1, RDATA1;
    logic [1:0]  GNT1;

    mem_bus_arbiter #(.FRAM_START(16'h4400), .FRAM_WAIT(1), .CNT_W(3)) dut0 (
        .MCLK(MCLK), .reset(rst0),
        .CPU_req(CPU_req0), .CPU_MAB(CPU_MAB0), .CPU_MDBwrite(CPU_MDBwrite0),
        .CPU_MW(CPU_MW0), .CPU_BW(CPU_BW0), .CPU_ack(CPU_ack0),
        .DMA_req(DMA_req0), .DMA_MAB(DMA_MAB0), .DMA_MDBwrite(DMA_MDBwrite0),
        .DMA_MW(DMA_MW0), .DMA_BW(DMA_BW0), .DMA_ack(DMA_ack0),
        .MAB(MAB0), .MDBwrite(MDBwrite0), .MW(MW0), .BW(BW0),
        .MDBread(MDBread0), .RDATA(RDATA0), .GNT(GNT0)
    );

    mem_bus_arbiter #(.FRAM_START(16'h4400), .FRAM_WAIT(3), .CNT_W(3)) dut1 (
        .MCLK(MCLK), .reset(rst1),
        .CPU_req(CPU_req1), .CPU_MAB(CPU_MAB1), .CPU_MDBwrite(CPU_MDBwrite1),
        .CPU_MW(CPU_MW1), .CPU_BW(CPU_BW1), .CPU_ack(CPU_ack1),
        .DMA_req(DMA_req1), .DMA_MAB(DMA_MAB1), .DMA_MDBwrite(DMA_MDBwrite1),
        .DMA_MW(DMA_MW1), .DMA_BW(DMA_BW1), .DMA_ack(DMA_ack1),
        .MAB(MAB1), .MDBwrite(MDBwrite1), .MW(MW1), .BW(BW1),
        .MDBread(MDBread1), .RDATA(RDATA1), .GNT(GNT1)
    );

    // Behavioural memories: word-addressed by MAB[15:1], byte lane chosen by MAB[0].
    logic [15:0] mem0 [0:32767];
    logic [15:0] mem1 [0:32767];
    logic [15:0] rw0, rw1;
    assign rw0 = mem0[MAB0[15:1]];
    assign rw1 = mem1[MAB1[15:1]];
    assign MDBread0 = BW0 ? (MAB0[0] ? {8'h00, rw0[15:8]} : {8'h00, rw0[7:0]}) : rw0;
    assign MDBread1 = BW1 ? (MAB1[0] ? {8'h00, rw1[15:8]} : {8'h00, rw1[7:0]}) : rw1;

    int mw_cnt0 = 0, mw_cnt1 = 0, cack_cnt0 = 0, dack_cnt1 = 0;

    always @(posedge MCLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 32768; i++) begin
                mem0[i] <= 16'h0000;
                mem1[i] <= 16'h0000;
            end
        end else begin
            if (MW0) begin
                if (!BW0)        mem0[MAB0[15:1]]       <= MDBwrite0;
                else if (MAB0[0]) mem0[MAB0[15:1]][15:8] <= MDBwrite0[7:0];
                else             mem0[MAB0[15:1]][7:0]  <= MDBwrite0[7:0];
            end
            if (MW1) begin
                if (!BW1)        mem1[MAB1[15:1]]       <= MDBwrite1;
                else if (MAB1[0]) mem1[MAB1[15:1]][15:8] <= MDBwrite1[7:0];
                else             mem1[MAB1[15:1]][7:0]  <= MDBwrite1[7:0];
            end
        end
        if (MW0)      mw_cnt0   <= mw_cnt0 + 1;
        if (MW1)      mw_cnt1   <= mw_cnt1 + 1;
        if (CPU_ack0) cack_cnt0 <= cack_cnt0 + 1;
        if (DMA_ack1) dack_cnt1 <= dack_cnt1 + 1;
    end

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (GNT0 !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b want 00", GNT0); end
        checks++; if ({MW0, BW0, CPU_ack0, DMA_ack0} !== 4'b0000) begin errors++; $display("FAIL rst_ctl got %b want 0000", {MW0, BW0, CPU_ack0, DMA_ack0}); end
        checks++; if ({MAB0, MDBwrite0, RDATA0} !== 48'h0) begin errors++; $display("FAIL rst_data got %h want 0", {MAB0, MDBwrite0, RDATA0}); end
    endtask

    task automatic test_fram_write();
        int m0;
        m0 = mw_cnt0;
        CPU_req0 = 1'b1; CPU_MAB0 = 16'h4400; CPU_MDBwrite0 = 16'h1234; CPU_MW0 = 1'b1; CPU_BW0 = 1'b0;
        step();
        checks++; if (GNT0 !== 2'b01) begin errors++; $display("FAIL wr_gnt got %b want 01", GNT0); end
        checks++; if (MW0 !== 1'b0) begin errors++; $display("FAIL wr_mw_wait got %b want 0", MW0); end
        CPU_MAB0 = 16'h0002; CPU_MDBwrite0 = 16'hFFFF;
        step();
        checks++; if (MW0 !== 1'b1) begin errors++; $display("FAIL wr_mw_final got %b want 1", MW0); end
        checks++; if ({MAB0, MDBwrite0} !== {16'h4400, 16'h1234}) begin errors++; $display("FAIL wr_bus got %h want 44001234", {MAB0, MDBwrite0}); end
        checks++; if (CPU_ack0 !== 1'b0) begin errors++; $display("FAIL wr_ack_early got %b want 0", CPU_ack0); end
        step();
        checks++; if (CPU_ack0 !== 1'b1) begin errors++; $display("FAIL wr_ack got %b want 1", CPU_ack0); end
        checks++; if ({MW0, GNT0} !== 3'b000) begin errors++; $display("FAIL wr_after got %b want 000", {MW0, GNT0}); end
        CPU_req0 = 1'b0;
        checks++; if (mem0[16'h2200] !== 16'h1234) begin errors++; $display("FAIL wr_mem got %h want 1234", mem0[16'h2200]); end
        checks++; if (mw_cnt0 - m0 != 1) begin errors++; $display("FAIL wr_mw_count got %0d want 1", mw_cnt0 - m0); end
        step();
        checks++; if (CPU_ack0 !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %b want 0", CPU_ack0); end
    endtask

    task automatic test_byte_read();
        CPU_req0 = 1'b1; CPU_MAB0 = 16'h4401; CPU_MW0 = 1'b0; CPU_BW0 = 1'b1;
        step();
        checks++; if (GNT0 !== 2'b01) begin errors++; $display("FAIL rd_gnt got %b want 01", GNT0); end
        step();
        checks++; if (CPU_ack0 !== 1'b0) begin errors++; $display("FAIL rd_ack_early got %b want 0", CPU_ack0); end
        step();
        checks++; if (CPU_ack0 !== 1'b1) begin errors++; $display("FAIL rd_ack got %b want 1", CPU_ack0); end
        checks++; if (RDATA0 !== 16'h0012) begin errors++; $display("FAIL rd_data got %h want 0012", RDATA0); end
        CPU_req0 = 1'b0;
        step();
    endtask

    task automatic test_nonfram_read();
        int m0;
        m0 = mw_cnt0;
        CPU_req0 = 1'b1; CPU_MAB0 = 16'h1C00; CPU_MW0 = 1'b0; CPU_BW0 = 1'b0;
        step();
        checks++; if (GNT0 !== 2'b01) begin errors++; $display("FAIL nf_gnt got %b want 01", GNT0); end
        step();
        checks++; if (CPU_ack0 !== 1'b1) begin errors++; $display("FAIL nf_ack got %b want 1", CPU_ack0); end
        checks++; if (RDATA0 !== 16'h0000) begin errors++; $display("FAIL nf_data got %h want 0000", RDATA0); end
        checks++; if (mw_cnt0 != m0) begin errors++; $display("FAIL nf_mw got %0d want %0d", mw_cnt0, m0); end
        CPU_req0 = 1'b0;
        step();
    endtask

    task automatic test_arbitration();
        rst0 = 1'b1; step(); rst0 = 1'b0;
        CPU_req0 = 1'b1; CPU_MAB0 = 16'h1C00; CPU_MW0 = 1'b0; CPU_BW0 = 1'b0;
        DMA_req0 = 1'b1; DMA_MAB0 = 16'h1C02; DMA_MW0 = 1'b0; DMA_BW0 = 1'b0;
        step();
        checks++; if (GNT0 !== 2'b01) begin errors++; $display("FAIL arb_first got %b want 01", GNT0); end
        step();
        checks++; if ({CPU_ack0, GNT0} !== 3'b100) begin errors++; $display("FAIL arb_cack got %b want 100", {CPU_ack0, GNT0}); end
        step();
        checks++; if (GNT0 !== 2'b10) begin errors++; $display("FAIL arb_second got %b want 10", GNT0); end
        step();
        checks++; if (DMA_ack0 !== 1'b1) begin errors++; $display("FAIL arb_dack got %b want 1", DMA_ack0); end
        step();
        checks++; if (GNT0 !== 2'b01) begin errors++; $display("FAIL arb_third got %b want 01", GNT0); end
        CPU_req0 = 1'b0; DMA_req0 = 1'b0;
        step();
        step();
        checks++; if (GNT0 !== 2'b00) begin errors++; $display("FAIL arb_idle got %b want 00", GNT0); end
        // CPU was granted last, so a simultaneous request must go to DMA.
        CPU_req0 = 1'b1; DMA_req0 = 1'b1;
        step();
        checks++; if (GNT0 !== 2'b10) begin errors++; $display("FAIL arb_tie got %b want 10", GNT0); end
        CPU_req0 = 1'b0; DMA_req0 = 1'b0;
        step();
        checks++; if (DMA_ack0 !== 1'b1) begin errors++; $display("FAIL arb_tie_ack got %b want 1", DMA_ack0); end
        step();
    endtask

    task automatic test_back_to_back();
        int a0;
        a0 = cack_cnt0;
        CPU_req0 = 1'b1; CPU_MAB0 = 16'h1C00; CPU_MW0 = 1'b0; CPU_BW0 = 1'b0;
        step();
        step();
        checks++; if (CPU_ack0 !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got %b want 1", CPU_ack0); end
        step();
        checks++; if ({CPU_ack0, GNT0} !== 3'b000) begin errors++; $display("FAIL b2b_masked got %b want 000", {CPU_ack0, GNT0}); end
        step();
        checks++; if (GNT0 !== 2'b01) begin errors++; $display("FAIL b2b_regrant got %b want 01", GNT0); end
        step();
        CPU_req0 = 1'b0;
        step();
        checks++; if (cack_cnt0 - a0 != 2) begin errors++; $display("FAIL b2b_acks got %0d want 2", cack_cnt0 - a0); end
        checks++; if (GNT0 !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b want 00", GNT0); end
    endtask

    task automatic test_reset_abort();
        DMA_req1 = 1'b1; DMA_MAB1 = 16'h4400; DMA_MDBwrite1 = 16'hABCD; DMA_MW1 = 1'b1; DMA_BW1 = 1'b0;
        step();
        checks++; if ({GNT1, MW1} !== 3'b100) begin errors++; $display("FAIL ab_grant got %b want 100", {GNT1, MW1}); end
        step();
        rst1 = 1'b1; DMA_req1 = 1'b0;
        step();
        rst1 = 1'b0;
        checks++; if ({GNT1, MW1, BW1, CPU_ack1, DMA_ack1} !== 6'b0) begin errors++; $display("FAIL ab_ctl got %b want 000000", {GNT1, MW1, BW1, CPU_ack1, DMA_ack1}); end
        checks++; if ({MAB1, MDBwrite1, RDATA1} !== 48'h0) begin errors++; $display("FAIL ab_data got %h want 0", {MAB1, MDBwrite1, RDATA1}); end
        repeat (5) step();
        checks++; if (dack_cnt1 != 0) begin errors++; $display("FAIL ab_no_ack got %0d want 0", dack_cnt1); end
        checks++; if (mw_cnt1 != 0) begin errors++; $display("FAIL ab_no_mw got %0d want 0", mw_cnt1); end
        checks++; if (mem1[16'h2200] !== 16'h0000) begin errors++; $display("FAIL ab_mem got %h want 0000", mem1[16'h2200]); end
    endtask

    initial begin
        mem_clr = 1'b1; rst0 = 1'b1; rst1 = 1'b1;
        CPU_req0 = 0; CPU_MAB0 = 0; CPU_MDBwrite0 = 0; CPU_MW0 = 0; CPU_BW0 = 0;
        DMA_req0 = 0; DMA_MAB0 = 0; DMA_MDBwrite0 = 0; DMA_MW0 = 0; DMA_BW0 = 0;
        CPU_req1 = 0; CPU_MAB1 = 0; CPU_MDBwrite1 = 0; CPU_MW1 = 0; CPU_BW1 = 0;
        DMA_req1 = 0; DMA_MAB1 = 0; DMA_MDBwrite1 = 0; DMA_MW1 = 0; DMA_BW1 = 0;
        step();
        step();
        mem_clr = 1'b0;
        test_reset();
        rst0 = 1'b0; rst1 = 1'b0;
        step();
        test_fram_write();
        test_byte_read();
        test_nonfram_read();
        test_arbitration();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
